data_ram_bank: RTL and testbench

DATA_RAM_BANK -- requirements
Module: data_ram_bank

---
 rtl/data_ram_bank.sv | 167 ++++++++++++++++
 tb/tb_data_ram_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_bank.sv
// Byte-lane-enabled single-port data RAM with registered read, sel/range error reporting.
// Optional power-up zero sweep enabled by defining DATA_RAM_CLEAR_EN.
module data_ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   data_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                valid_o,
    output logic                err_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int LGB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP   = IDX_W + LGB;
    localparam logic [BYTES-1:0] ONES = '1;

    logic [IDX_W-1:0]     idx;
    logic                 in_range;
    logic                 legal;
    logic [LGB:0][BYTES-1:0] hit;
    logic                 acc;
    logic                 ok;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 clearing;
    logic [IDX_W-1:0]     clr_word;
    logic [IDX_W-1:0]     wr_idx;
    logic [BYTES-1:0]     wr_be;
    logic [DATA_W-1:0]    wr_data;
    logic [DATA_W-1:0]    rd_word;
    logic                 valid_reg;
    logic                 err_reg;
    logic [DATA_W-1:0]    mem [DEPTH];

    assign idx = addr[TOP-1:LGB];

    generate
        if (ADDR_W > TOP) begin : g_range
            assign in_range = ~|addr[ADDR_W-1:TOP];
        end else begin : g_norange
            assign in_range = 1'b1;
        end
        if (LGB > 0) begin : g_lowbits
            logic unused_low_bits;
            assign unused_low_bits = ^addr[LGB-1:0];
        end
    endgenerate

    // Each legal sel is a run of 2^gi ones starting on a multiple of 2^gi.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LGB; gi++) begin : g_size
            localparam int W = 1 << gi;
            for (gj = 0; gj < BYTES; gj++) begin : g_pos
                if (gj < BYTES / W) begin : g_on
                    localparam logic [BYTES-1:0] MASK = (ONES >> (BYTES - W)) << (gj * W);
                    assign hit[gi][gj] = (sel == MASK);
                end else begin : g_off
                    assign hit[gi][gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign legal   = |hit;
    assign acc     = ce & ready_o;
    assign ok      = legal & in_range;
    assign wr_fire = acc & we & ok;
    assign rd_fire = acc & ~we & ok;

`ifdef DATA_RAM_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t           state_reg, state_next;
    logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        clearing     = 1'b0;
        case (state_reg)
            CLEAR: begin
                clearing     = 1'b1;
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == IDX_W'(DEPTH - 1))
                    state_next = IDLE;
            end
            IDLE: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready_o  = (state_reg == IDLE);
    assign clr_word = clr_idx_reg;
`else
    logic ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ready_reg <= 1'b0;
        else
            ready_reg <= 1'b1;
    end

    assign ready_o  = ready_reg;
    assign clearing = 1'b0;
    assign clr_word = '0;
`endif

    // The sweep and user writes share the single write port; they never overlap.
    always_comb begin
        wr_idx  = idx;
        wr_be   = '0;
        wr_data = data_i;
        if (clearing) begin
            wr_idx  = clr_word;
            wr_be   = '1;
            wr_data = '0;
        end else if (wr_fire) begin
            wr_be = sel;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b])
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (rd_fire)
            rd_word <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= rd_fire;
            err_reg   <= acc & ~ok;
        end
    end

    // Gating keeps data_o at zero whenever no read result is being presented.
    assign data_o  = valid_reg ? rd_word : '0;
    assign valid_o = valid_reg;
    assign err_o   = err_reg;

endmodule

// File: tb/tb_data_ram_bank.sv
// Randomized bench for data_ram_bank against an array-based reference model.
// Works with or without DATA_RAM_CLEAR_EN defined.
module tb_data_ram_bank;
    localparam int DEPTH = 16;

`ifdef DATA_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [DEPTH];

    data_ram_bank #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Legal: 1, 2 or 4 contiguous lanes, starting on a multiple of the run length.
    function automatic bit sel_legal(input logic [3:0] s);
        int p;
        int lo;
        logic [3:0] run;
        p = $countones(s);
        if (p == 0 || p == 3) return 1'b0;
        lo = 0;
        while (!s[lo]) lo++;
        run = 4'((1 << p) - 1) << lo;
        return (s == run) && (lo % p == 0);
    endfunction

    task automatic apply(input bit c, input bit w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        bit          ok;
        int          i;
        logic        exp_v;
        logic        exp_e;
        logic [31:0] exp_d;
        @(negedge clk);
        ce = c; we = w; addr = a; sel = s; data_i = d;
        check("ready", ready_o, 1);
        ok    = sel_legal(s) && (a < DEPTH * 4);
        i     = int'((a >> 2) % DEPTH);
        exp_v = c && !w && ok;
        exp_e = c && !ok;
        exp_d = exp_v ? model[i] : 32'h0;
        @(posedge clk);
        #1;
        check("valid", valid_o, exp_v);
        check("err", err_o, exp_e);
        check("rdata", data_o, exp_d);
        check("excl", valid_o & err_o, 0);
        if (c && w && ok) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
        end
        $display("txn ce=%0b we=%0b addr=%h sel=%b wdata=%h -> valid=%0b err=%0b rdata=%h",
                 c, w, a, s, d, valid_o, err_o, data_o);
    endtask

    task automatic count_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 200);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready_o, 0);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_data"}, data_o, 0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        for (int k = 0; k < DEPTH; k++) model[k] = 32'h0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        count_ready(n);
        check("ready_delay", n, CLR ? DEPTH : 1);

        if (CLR) begin
            for (int k = 0; k < DEPTH; k++) apply(1'b1, 1'b0, 32'(k * 4), 4'hF, 32'h0);
        end

        // Reset in the middle of the sweep must restart it from word 0.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midclr_ready", ready_o, CLR ? 0 : 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        count_ready(n);
        check("ready_delay2", n, CLR ? DEPTH : 1);

        if (!CLR) begin
            for (int k = 0; k < DEPTH; k++) apply(1'b1, 1'b1, 32'(k * 4), 4'hF, $urandom);
        end

        apply(1'b1, 1'b1, 32'h8, 4'b1111, 32'hAABBCCDD);
        apply(1'b1, 1'b1, 32'h8, 4'b0001, 32'h000000EE);
        apply(1'b1, 1'b0, 32'h8, 4'b1111, 32'h0);
        check("lanes", data_o, 32'hAABBCCEE);

        apply(1'b1, 1'b1, 32'h4, 4'b1111, 32'h11111111);
        apply(1'b1, 1'b0, 32'h4, 4'b1111, 32'h0);
        check("b2b_first", data_o, 32'h11111111);
        apply(1'b1, 1'b0, 32'h0, 4'b1111, 32'h0);
        check("b2b_second_valid", valid_o, 1);

        apply(1'b1, 1'b1, 32'hC, 4'b0110, 32'hFFFFFFFF);
        check("illegal_sel_err", err_o, 1);
        apply(1'b1, 1'b0, 32'hC, 4'b1111, 32'h0);

        apply(1'b1, 1'b0, 32'h40, 4'b1111, 32'h0);
        check("oor_err", err_o, 1);
        check("oor_valid", valid_o, 0);
        check("oor_data", data_o, 0);

        for (int t = 0; t < 400; t++) begin
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
            apply($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, a,
                  4'($urandom_range(0, 15)), $urandom);
        end
        apply(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
